// File: rtl/address_generation_if.sv
// Stage bus for the address-generation block: decoded-instruction fields
// coming in (d_*) and address-resolved fields going out (a_*).
// slave  : the view taken by the stage itself.
// master : the view taken by the surrounding pipeline (decoder + consumer).
interface address_generation_if;
   // upstream: decoder -> stage
   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_size;
   logic        d_set_d_flag;
   logic        d_clear_d_flag;
   logic [31:0] d_base;
   logic        d_base_valid;
   logic [31:0] d_index;
   logic        d_index_valid;
   logic [1:0]  d_scale;
   logic [31:0] d_disp;
   logic [31:0] d_seg_base;
   logic [63:0] d_op0_val;
   logic [63:0] d_op1_val;
   logic [2:0]  d_op0_reg;
   logic [2:0]  d_op1_reg;
   logic        d_op0_is_mem;
   logic        d_op1_is_mem;
   logic [47:0] d_imm;
   logic [3:0]  d_alu_op;
   logic [2:0]  d_flag_0;
   logic [2:0]  d_flag_1;
   logic [1:0]  d_stack_op;
   logic [31:0] d_pc;
   logic        d_branch_taken;
   logic        d_to_sys_controller;
   // downstream: stage -> consumer
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_size;
   logic        a_set_d_flag;
   logic        a_clear_d_flag;
   logic [63:0] a_op0;
   logic [63:0] a_op1;
   logic [2:0]  a_op0_reg;
   logic [2:0]  a_op1_reg;
   logic        a_op0_is_address;
   logic        a_op1_is_address;
   logic [47:0] a_imm;
   logic [3:0]  a_alu_op;
   logic [2:0]  a_flag_0;
   logic [2:0]  a_flag_1;
   logic [1:0]  a_stack_op;
   logic [31:0] a_pc;
   logic        a_branch_taken;
   logic        a_to_sys_controller;

   modport slave (
      input  d_valid, d_size, d_set_d_flag, d_clear_d_flag, d_base, d_base_valid,
             d_index, d_index_valid, d_scale, d_disp, d_seg_base, d_op0_val, d_op1_val,
             d_op0_reg, d_op1_reg, d_op0_is_mem, d_op1_is_mem, d_imm, d_alu_op,
             d_flag_0, d_flag_1, d_stack_op, d_pc, d_branch_taken, d_to_sys_controller,
      output d_ready,
      output a_valid, a_size, a_set_d_flag, a_clear_d_flag, a_op0, a_op1, a_op0_reg,
             a_op1_reg, a_op0_is_address, a_op1_is_address, a_imm, a_alu_op, a_flag_0,
             a_flag_1, a_stack_op, a_pc, a_branch_taken, a_to_sys_controller,
      input  a_ready
   );

   modport master (
      output d_valid, d_size, d_set_d_flag, d_clear_d_flag, d_base, d_base_valid,
             d_index, d_index_valid, d_scale, d_disp, d_seg_base, d_op0_val, d_op1_val,
             d_op0_reg, d_op1_reg, d_op0_is_mem, d_op1_is_mem, d_imm, d_alu_op,
             d_flag_0, d_flag_1, d_stack_op, d_pc, d_branch_taken, d_to_sys_controller,
      input  d_ready,
      input  a_valid, a_size, a_set_d_flag, a_clear_d_flag, a_op0, a_op1, a_op0_reg,
             a_op1_reg, a_op0_is_address, a_op1_is_address, a_imm, a_alu_op, a_flag_0,
             a_flag_1, a_stack_op, a_pc, a_branch_taken, a_to_sys_controller,
      output a_ready
   );
endinterface

// File: rtl/address_generation_top.sv
// Address-generation pipeline stage: one registered entry that resolves the
// effective address, turns push/pop into stack addresses using a speculative
// ESP, and passes every other decoded field through.
module address_generation_top (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   input  logic [31:0]                 flush_esp,
   address_generation_if.slave         bus
);
   localparam logic [1:0] STACK_PUSH = 2'd1;
   localparam logic [1:0] STACK_POP  = 2'd2;

   typedef struct packed {
      logic [2:0]  size;
      logic        set_d_flag;
      logic        clear_d_flag;
      logic [63:0] op0;
      logic [63:0] op1;
      logic [2:0]  op0_reg;
      logic [2:0]  op1_reg;
      logic        op0_is_address;
      logic        op1_is_address;
      logic [47:0] imm;
      logic [3:0]  alu_op;
      logic [2:0]  flag_0;
      logic [2:0]  flag_1;
      logic [1:0]  stack_op;
      logic [31:0] pc;
      logic        branch_taken;
      logic        to_sys_controller;
   } out_t;

   out_t        out_reg, out_next;
   logic        a_valid_reg;
   logic [31:0] sp_spec_reg, sp_spec_next;
   logic        accept;
   logic [31:0] size_bytes;
   logic [31:0] ea;
   logic [31:0] push_sp;
   logic [63:0] op_val_in   [2];
   logic        op_is_mem_in [2];
   logic [63:0] op_plain    [2];

   assign bus.d_ready = (~a_valid_reg | bus.a_ready) & ~flush;
   assign accept      = bus.d_valid & bus.d_ready;

   // access width in bytes; undefined codes fall back to a dword
   always_comb begin
      case (bus.d_size)
         3'd0:    size_bytes = 32'd1;
         3'd1:    size_bytes = 32'd2;
         3'd2:    size_bytes = 32'd4;
         3'd3:    size_bytes = 32'd8;
         default: size_bytes = 32'd4;
      endcase
   end

   assign ea = bus.d_seg_base
             + (bus.d_base_valid  ? bus.d_base : 32'd0)
             + (bus.d_index_valid ? (bus.d_index << bus.d_scale) : 32'd0)
             + bus.d_disp;

   assign push_sp = sp_spec_reg - size_bytes;

   assign op_val_in[0]    = bus.d_op0_val;
   assign op_val_in[1]    = bus.d_op1_val;
   assign op_is_mem_in[0] = bus.d_op0_is_mem;
   assign op_is_mem_in[1] = bus.d_op1_is_mem;

   // non-stack operand value: memory operands carry the effective address
   for (genvar gi = 0; gi < 2; gi++) begin : g_op
      assign op_plain[gi] = op_is_mem_in[gi] ? {32'b0, ea} : op_val_in[gi];
   end

   // next output entry and next speculative ESP for an accepted transfer
   always_comb begin
      out_next                   = '0;
      out_next.size              = bus.d_size;
      out_next.set_d_flag        = bus.d_set_d_flag;
      out_next.clear_d_flag      = bus.d_clear_d_flag;
      out_next.op0               = op_plain[0];
      out_next.op1               = op_plain[1];
      out_next.op0_reg           = bus.d_op0_reg;
      out_next.op1_reg           = bus.d_op1_reg;
      out_next.op0_is_address    = bus.d_op0_is_mem;
      out_next.op1_is_address    = bus.d_op1_is_mem;
      out_next.imm               = bus.d_imm;
      out_next.alu_op            = bus.d_alu_op;
      out_next.flag_0            = bus.d_flag_0;
      out_next.flag_1            = bus.d_flag_1;
      out_next.stack_op          = bus.d_stack_op;
      out_next.pc                = bus.d_pc;
      out_next.branch_taken      = bus.d_branch_taken;
      out_next.to_sys_controller = bus.d_to_sys_controller;
      sp_spec_next               = sp_spec_reg;
      case (bus.d_stack_op)
         STACK_PUSH: begin
            // push writes below the current top: pre-decrement
            sp_spec_next            = push_sp;
            out_next.op0            = {32'b0, bus.d_seg_base + push_sp};
            out_next.op0_is_address = 1'b1;
            out_next.op1            = bus.d_op1_val;
            out_next.op1_is_address = 1'b0;
         end
         STACK_POP: begin
            // pop reads the current top: post-increment
            sp_spec_next            = sp_spec_reg + size_bytes;
            out_next.op1            = {32'b0, bus.d_seg_base + sp_spec_reg};
            out_next.op1_is_address = 1'b1;
         end
         default: ;
      endcase
   end

   // pipeline register: flush beats any transfer, drain on downstream take
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_valid_reg <= 1'b0;
         sp_spec_reg <= 32'h0000_0000;
         out_reg     <= '0;
      end else if (flush) begin
         a_valid_reg <= 1'b0;
         sp_spec_reg <= flush_esp;
      end else if (accept) begin
         a_valid_reg <= 1'b1;
         sp_spec_reg <= sp_spec_next;
         out_reg     <= out_next;
      end else if (bus.a_ready) begin
         a_valid_reg <= 1'b0;
      end
   end

   assign bus.a_valid             = a_valid_reg;
   assign bus.a_size              = out_reg.size;
   assign bus.a_set_d_flag        = out_reg.set_d_flag;
   assign bus.a_clear_d_flag      = out_reg.clear_d_flag;
   assign bus.a_op0               = out_reg.op0;
   assign bus.a_op1               = out_reg.op1;
   assign bus.a_op0_reg           = out_reg.op0_reg;
   assign bus.a_op1_reg           = out_reg.op1_reg;
   assign bus.a_op0_is_address    = out_reg.op0_is_address;
   assign bus.a_op1_is_address    = out_reg.op1_is_address;
   assign bus.a_imm               = out_reg.imm;
   assign bus.a_alu_op            = out_reg.alu_op;
   assign bus.a_flag_0            = out_reg.flag_0;
   assign bus.a_flag_1            = out_reg.flag_1;
   assign bus.a_stack_op          = out_reg.stack_op;
   assign bus.a_pc                = out_reg.pc;
   assign bus.a_branch_taken      = out_reg.branch_taken;
   assign bus.a_to_sys_controller = out_reg.to_sys_controller;
endmodule
